pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//   Parametrised, pipelined successor to the combinational CORDIC shifter. Shifts a WIDTH-bit word
//   by a per-transaction amount, one power-of-two stage per pipeline register.
//   Modes: arithmetic right, logical right, logical left and rotate right.
//   Valid/ready handshakes on both sides. A TAG sideband (e.g. CORDIC iteration index) travels with the data.
//   Sits between the CORDIC iteration control and the add/sub datapath.
// PARAMETERS
//   WIDTH   16  data width in bits (>=2)
//   SHIFT_W 4   shift-amount width; also the number of stages and the latency (>=1)
//   TAG_W   4   sideband width carried unchanged (>=1)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        input transaction present
//   in_ready   out  1        block accepts input this cycle
//   in_data    in   WIDTH    operand
//   in_shift   in   SHIFT_W  shift amount, unsigned
//   in_mode    in   2        00 arith-right, 01 logical-right, 10 logical-left, 11 rotate-right
//   in_tag     in   TAG_W    sideband
//   out_valid  out  1        result present
//   out_ready  in   1        downstream accepts result
//   out_data   out  WIDTH    shifted result
//   out_tag    out  TAG_W    sideband of the same transaction
// BEHAVIOUR
//   - Stage k (k=0..SHIFT_W-1) holds the registers v[k], data, remaining shift bits, mode and tag.
//     Stage k applies a shift of 2^k when shift bit k = 1. Otherwise it passes the data through.
//   - Per-stage fill rules, with s=2^k:
//       arith-right: the top s bits take the current MSB.
//       logical-right and logical-left: vacated bits take 0.
//       rotate-right: bits wrap around.
//     If s>=WIDTH: arith gives all bits = MSB, logical gives 0, rotate shifts by s mod WIDTH.
//   - Net result = shift by in_shift with the per-mode semantics above.
//     Rotate results are by in_shift mod WIDTH.
//   - Latency: exactly SHIFT_W cycles from the in handshake to out_valid, when there is no backpressure.
//   - Throughput: 1 transaction per cycle.
//   - Advance rule: adv[k] = !v[k] || adv[k+1], with adv[SHIFT_W] = out_ready.
//     in_ready = adv[0] (combinational). The input is accepted when in_valid && in_ready.
//   - A stage loads when adv[k]. v[k] <= v[k-1] (stage 0 loads in_valid && in_ready).
//     Stalled stages hold all their fields.
//   - Bubbles collapse: an empty stage accepts data even when downstream is stalled.
//   - out_valid = v[SHIFT_W-1]. out_data and out_tag are the registered fields of the last stage.
//     They are stable while out_valid && !out_ready.
//   - Data, tag, mode and amount are never reordered, duplicated or dropped.
//     Transactions leave in acceptance order.
//   - Reset (any time, including mid-stream): all v[k]=0 and all data/tag registers =0 immediately.
//     So out_valid=0, out_data=0, out_tag=0, and in_ready=1 once rst is low.
//     In-flight transactions are discarded.
//   - When rst is deasserted, the first transaction can be accepted on the next rising edge.
//   - in_shift=0 in any mode: out_data == in_data.
// TESTING
//   1 Arith-right, WIDTH=16: in_data=16'h8000, shift=4 -> out_data=16'hF800 exactly 4 cycles later;
//     0x7FF0 with shift=15 -> 16'h0000.
//   2 Modes: in_data=16'h8001, shift=1:
//       arith-right  -> 16'hC000
//       logical-right -> 16'h4000
//       logical-left -> 16'h0002
//       rotate-right -> 16'hC000
//   3 Streaming: 16 back-to-back inputs (data=i, shift=i%16, tag=i) with out_ready=1.
//     Expect one output per cycle, in order, matching the model, with tag=i.
//   4 Backpressure: fill the pipe, drop out_ready for 5 cycles.
//     out_data and out_tag hold; in_ready=0 once all stages are full.
//     Release -> no loss or duplication.
//   5 Bubbles: single input, out_ready=0 -> it reaches the last stage;
//     3 more inputs are accepted (in_ready stays 1) until the pipe is full.
//   6 Reset mid-stream: assert rst with 3 transactions in flight -> out_valid=0 and outputs 0 asynchronously.
//     After release, none of the old transactions appear, and a new input emerges after SHIFT_W cycles.
//   Scoreboard: a reference model checks every output in all tests, including random mode/shift
//   with SHIFT_W=5 (shift>=WIDTH cases).

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one power-of-two shift stage per register, valid/ready on both sides.
// Modes: 00 arith-right, 01 logical-right, 10 logical-left, 11 rotate-right; tag rides along.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHIFT_W = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic [SHIFT_W-1:0]              v;
  logic [SHIFT_W-1:0][WIDTH-1:0]   data;
  logic [SHIFT_W-1:0][SHIFT_W-1:0] amt;
  logic [SHIFT_W-1:0][1:0]         mode;
  logic [SHIFT_W-1:0][TAG_W-1:0]   tag;
  logic [SHIFT_W:0]                adv;

  // A stage may load if it is empty or its contents move on this cycle.
  always_comb begin
    adv          = '0;
    adv[SHIFT_W] = out_ready;
    for (int k = int'(SHIFT_W) - 1; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    localparam int unsigned Step = 1 << k;
    localparam int unsigned Rot  = Step % WIDTH;

    logic               src_v;
    logic [WIDTH-1:0]   src_d;
    logic [SHIFT_W-1:0] src_a;
    logic [1:0]         src_m;
    logic [TAG_W-1:0]   src_t;
    logic [WIDTH-1:0]   asr, lsr, lsl, ror, shifted;
    logic               v_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHIFT_W-1:0] amt_q;
    logic [1:0]         mode_q;
    logic [TAG_W-1:0]   tag_q;

    if (k == 0) begin : g_head
      assign src_v = in_valid && in_ready;
      assign src_d = in_data;
      assign src_a = in_shift;
      assign src_m = in_mode;
      assign src_t = in_tag;
    end else begin : g_body
      assign src_v = v[k-1];
      assign src_d = data[k-1];
      assign src_a = amt[k-1];
      assign src_m = mode[k-1];
      assign src_t = tag[k-1];
    end

    if (Step >= WIDTH) begin : g_sat
      assign asr = {WIDTH{src_d[WIDTH-1]}};
      assign lsr = '0;
      assign lsl = '0;
    end else begin : g_part
      assign asr = $signed(src_d) >>> Step;
      assign lsr = src_d >> Step;
      assign lsl = src_d << Step;
    end

    if (Rot == 0) begin : g_rot_id
      assign ror = src_d;
    end else begin : g_rot
      assign ror = (src_d >> Rot) | (src_d << (WIDTH - Rot));
    end

    always_comb begin
      shifted = src_d;
      if (src_a[k]) begin
        unique case (src_m)
          2'b00:   shifted = asr;
          2'b01:   shifted = lsr;
          2'b10:   shifted = lsl;
          default: shifted = ror;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q    <= 1'b0;
        data_q <= '0;
        amt_q  <= '0;
        mode_q <= '0;
        tag_q  <= '0;
      end else if (adv[k]) begin
        v_q <= src_v;
        // Fields only change on a real transfer so the output word holds while empty.
        if (src_v) begin
          data_q <= shifted;
          amt_q  <= src_a;
          mode_q <= src_m;
          tag_q  <= src_t;
        end
      end
    end

    assign v[k]    = v_q;
    assign data[k] = data_q;
    assign amt[k]  = amt_q;
    assign mode[k] = mode_q;
    assign tag[k]  = tag_q;
  end

  assign out_valid = v[SHIFT_W-1];
  assign out_data  = data[SHIFT_W-1];
  assign out_tag   = tag[SHIFT_W-1];

  // Low amount bits and the last stage's amount/mode are not consumed downstream.
  logic unused_bits;
  assign unused_bits = ^{amt, mode};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and random scoreboard bench for pipelined_barrel_shifter (SHIFT_W=4 and SHIFT_W=5).
module tb_pipelined_barrel_shifter;

  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_shift, in_tag, out_tag;
  logic [1:0]  in_mode;

  logic        in_valid5, in_ready5, out_valid5, out_ready5;
  logic [15:0] in_data5, out_data5;
  logic [4:0]  in_shift5;
  logic [3:0]  in_tag5, out_tag5;
  logic [1:0]  in_mode5;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  exp_t e4, e5;
  int   checks = 0;
  int   failures = 0;
  int   pops4 = 0;
  int   pops5 = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(16), .SHIFT_W(4), .TAG_W(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shift (in_shift),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  pipelined_barrel_shifter #(.WIDTH(16), .SHIFT_W(5), .TAG_W(4)) u_dut5 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid5),
    .in_ready (in_ready5),
    .in_data  (in_data5),
    .in_shift (in_shift5),
    .in_mode  (in_mode5),
    .in_tag   (in_tag5),
    .out_valid(out_valid5),
    .out_ready(out_ready5),
    .out_data (out_data5),
    .out_tag  (out_tag5)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Whole-amount reference, independent of the per-stage decomposition.
  function automatic logic [15:0] model(input logic [15:0] d, input int sh, input logic [1:0] m);
    logic signed [15:0] sd;
    int r;
    sd = d;
    if (m == 2'b00) begin
      if (sh >= 16) model = {16{d[15]}};
      else model = sd >>> sh;
    end else if (m == 2'b01) begin
      if (sh >= 16) model = 16'h0;
      else model = d >> sh;
    end else if (m == 2'b10) begin
      if (sh >= 16) model = 16'h0;
      else model = d << sh;
    end else begin
      r = sh % 16;
      if (r == 0) model = d;
      else model = (d >> r) | (d << (16 - r));
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q4.size() == 0) begin
        chk("unexpected_output", {16'h0, out_data}, 32'hdead);
      end else begin
        e4 = q4.pop_front();
        chk("out_data", {16'h0, out_data}, {16'h0, e4.d});
        chk("out_tag", {28'h0, out_tag}, {28'h0, e4.t});
        pops4++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid5 && out_ready5) begin
      if (q5.size() == 0) begin
        chk("unexpected_output5", {16'h0, out_data5}, 32'hdead);
      end else begin
        e5 = q5.pop_front();
        chk("out_data5", {16'h0, out_data5}, {16'h0, e5.d});
        chk("out_tag5", {28'h0, out_tag5}, {28'h0, e5.t});
        pops5++;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [3:0] sh, input logic [1:0] m,
                      input logic [3:0] t, input logic [15:0] exp, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = sh;
    in_mode  = m;
    in_tag   = t;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready) begin
      q4.push_back('{d: exp, t: t});
      @(posedge clk);
      #1;
    end else begin
      chk("send_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_lat(input string name);
    for (int c = 1; c <= SW; c++) begin
      @(negedge clk);
      #1;
      chk(name, {31'h0, out_valid}, {31'h0, (c == SW)});
    end
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 40 && q4.size() != 0; n++) @(posedge clk);
    #1;
    chk(name, q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   p0;
    logic [15:0] exp0;
    logic acc;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    in_valid5 = 1'b0; in_data5 = '0; in_shift5 = '0; in_mode5 = '0; in_tag5 = '0;
    out_ready5 = 1'b0;
    #2;
    chk("reset_out_valid", {31'h0, out_valid}, 0);
    chk("reset_out_data", {16'h0, out_data}, 0);
    chk("reset_out_tag", {28'h0, out_tag}, 0);
    sync();
    rst = 1'b0;
    chk("reset_in_ready", {31'h0, in_ready}, 1);

    // 1: arithmetic right with exact latency
    out_ready = 1'b1;
    send(16'h8000, 4'd4, 2'b00, 4'd1, 16'hF800, w);
    check_lat("t1_latency");
    sync();
    send(16'h7FF0, 4'd15, 2'b00, 4'd2, 16'h0000, w);
    wait_drain("t1_drain");

    // 2: each mode on the same operand
    send(16'h8001, 4'd1, 2'b00, 4'd3, 16'hC000, w);
    send(16'h8001, 4'd1, 2'b01, 4'd4, 16'h4000, w);
    send(16'h8001, 4'd1, 2'b10, 4'd5, 16'h0002, w);
    send(16'h8001, 4'd1, 2'b11, 4'd6, 16'hC000, w);
    wait_drain("t2_drain");

    // 3: back-to-back stream, one result per cycle
    p0 = pops4;
    for (int i = 0; i < 16; i++) begin
      send(16'(i), 4'(i % 16), 2'(i), 4'(i), model(16'(i), i % 16, 2'(i)), w);
      chk("t3_no_stall", w, 0);
    end
    repeat (4) @(negedge clk);
    #1;
    chk("t3_throughput", pops4 - p0, 16);
    sync();
    wait_drain("t3_drain");

    // 4: backpressure holds outputs and stops input
    out_ready = 1'b0;
    p0 = pops4;
    exp0 = model(16'hA5A5, 1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      send(16'hA5A5 + 16'(i), 4'(i + 1), 2'(i), 4'(8 + i),
           model(16'hA5A5 + 16'(i), i + 1, 2'(i)), w);
    end
    @(negedge clk);
    #1;
    chk("t4_in_ready_full", {31'h0, in_ready}, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("t4_hold_valid", {31'h0, out_valid}, 1);
      chk("t4_hold_data", {16'h0, out_data}, {16'h0, exp0});
      chk("t4_hold_tag", {28'h0, out_tag}, 32'd8);
    end
    sync();
    out_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_count", pops4 - p0, 4);

    // 5: bubbles collapse behind a stalled head
    out_ready = 1'b0;
    send(16'hF00F, 4'd3, 2'b01, 4'd3, 16'h1E01, w);
    check_lat("t5_reach_last");
    sync();
    for (int i = 0; i < 3; i++) begin
      send(16'h0F0F, 4'(i), 2'b10, 4'(12 + i), model(16'h0F0F, i, 2'b10), w);
      chk("t5_bubble_accept", w, 0);
    end
    @(negedge clk);
    #1;
    chk("t5_full", {31'h0, in_ready}, 0);
    sync();
    out_ready = 1'b1;
    wait_drain("t5_drain");

    // 6: asynchronous reset with three in flight
    out_ready = 1'b0;
    send(16'h1234, 4'd0, 2'b11, 4'd5, 16'h1234, w);
    check_lat("t6_fill");
    sync();
    send(16'h5555, 4'd2, 2'b01, 4'd6, 16'h1555, w);
    send(16'h00FF, 4'd8, 2'b10, 4'd7, 16'hFF00, w);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'h0, out_valid}, 0);
    chk("t6_rst_data", {16'h0, out_data}, 0);
    chk("t6_rst_tag", {28'h0, out_tag}, 0);
    q4.delete();
    sync();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t6_in_ready", {31'h0, in_ready}, 1);
    p0 = pops4;
    send(16'h0F00, 4'd4, 2'b11, 4'd9, 16'h00F0, w);
    check_lat("t6_latency");
    sync();
    wait_drain("t6_drain");
    chk("t6_count", pops4 - p0, 1);

    // Random modes and amounts up to 31 on the five-stage instance
    for (int n = 0; n < 400; n++) begin
      out_ready5 = ($urandom_range(0, 3) != 0);
      if (!in_valid5 && $urandom_range(0, 3) != 0) begin
        in_valid5 = 1'b1;
        in_data5  = 16'($urandom);
        in_shift5 = 5'($urandom_range(0, 31));
        in_mode5  = 2'($urandom_range(0, 3));
        in_tag5   = 4'($urandom);
      end
      @(negedge clk);
      acc = in_valid5 && in_ready5;
      if (acc) q5.push_back('{d: model(in_data5, int'(in_shift5), in_mode5), t: in_tag5});
      sync();
      if (acc) in_valid5 = 1'b0;
    end
    in_valid5 = 1'b0;
    out_ready5 = 1'b1;
    for (int n = 0; n < 40 && q5.size() != 0; n++) @(posedge clk);
    #1;
    chk("r5_drain", q5.size(), 0);
    chk("r5_some_outputs", {31'h0, (pops5 > 100)}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
